// File: rtl/nested_loop_pkg.sv
// Shared types and width helpers for the nested loop-index generator.
package nested_loop_pkg;

    // Sweep controller states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Default geometry: three levels of 4-bit indices.
    localparam int CNT_WIDTH_DEF = 4;
    localparam int NUM_LVL_DEF   = 3;
    localparam int IDX_WIDTH_DEF = NUM_LVL_DEF * CNT_WIDTH_DEF;

    // Width of the packed index / limit buses for a given geometry.
    function automatic int idx_width(input int num_lvl, input int cnt_width);
        return num_lvl * cnt_width;
    endfunction

endpackage

// File: rtl/loop_level_cnt.sv
// One level of the nested loop counter: an index that advances when the
// level is stepped and every lower level sits at its limit, wrapping to 0
// once it passes its own inclusive limit.
module loop_level_cnt
    import nested_loop_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step,
    input  logic                 at_limit_in,
    input  logic [CNT_WIDTH-1:0] limit,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] index,
    output logic                 at_limit_out,
    output logic                 wrap
);

    localparam logic [CNT_WIDTH-1:0] IDX_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] IDX_ZERO = {CNT_WIDTH{1'b0}};

    logic [CNT_WIDTH-1:0] index_r;
    logic [CNT_WIDTH-1:0] index_nxt_s;
    logic                 local_at_lim_s;
    logic                 adv_s;

    // Advance decision and next index: clear dominates, then wrap or increment.
    always_comb begin
        local_at_lim_s = (index_r == limit);
        adv_s          = step & at_limit_in;
        index_nxt_s    = index_r;
        if (clr) begin
            index_nxt_s = IDX_ZERO;
        end else if (adv_s) begin
            if (local_at_lim_s) begin
                index_nxt_s = IDX_ZERO;
            end else begin
                index_nxt_s = index_r + IDX_ONE;
            end
        end else begin
            index_nxt_s = index_r;
        end
    end

    // Index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_r <= IDX_ZERO;
        end else begin
            index_r <= index_nxt_s;
        end
    end

    assign index        = index_r;
    assign at_limit_out = local_at_lim_s;
    assign wrap         = adv_s & local_at_lim_s & ~clr;

endmodule

// File: rtl/nested_loop_counter.sv
// Multi-level loop-index generator. Level 0 is innermost; each level has its
// own inclusive limit latched at start. Emits per-level wrap pulses and a
// single-cycle done pulse when the whole sweep completes.
module nested_loop_counter
    import nested_loop_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int NUM_LVL   = NUM_LVL_DEF
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           start_i,
    input  logic [NUM_LVL*CNT_WIDTH-1:0]   limit_i,
    input  logic                           en_i,
    input  logic                           clr_i,
    output logic [NUM_LVL*CNT_WIDTH-1:0]   cnt_ff,
    output logic [NUM_LVL-1:0]             wrap_o,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int IDX_W = idx_width(NUM_LVL, CNT_WIDTH);

    state_e             state_r;
    logic [IDX_W-1:0]   limit_r;
    logic [NUM_LVL-1:0] wrap_r;
    logic               busy_r;
    logic               done_r;

    logic [NUM_LVL-1:0] wrap_s;
    logic [NUM_LVL-1:0] lvl_at_lim_s;
    logic [NUM_LVL:0]   carry_s;
    logic               start_s;
    logic               step_s;
    logic               lvl_clr_s;
    logic               complete_s;

    // Qualify start/step by state, with clear taking priority over both.
    always_comb begin
        start_s    = (state_r == IDLE) & start_i & ~clr_i;
        step_s     = (state_r == RUN) & en_i & ~clr_i;
        lvl_clr_s  = clr_i | start_s;
        complete_s = step_s & carry_s[NUM_LVL];
    end

    // Carry chain: level k may step only when all lower levels are at limit.
    always_comb begin
        carry_s    = {(NUM_LVL+1){1'b0}};
        carry_s[0] = 1'b1;
        for (int k = 0; k < NUM_LVL; k++) begin
            carry_s[k+1] = carry_s[k] & lvl_at_lim_s[k];
        end
    end

    for (genvar g = 0; g < NUM_LVL; g++) begin : g_lvl
        loop_level_cnt #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_lvl (
            .clk          (clk_i),
            .rst_n        (rst_n_i),
            .step         (step_s),
            .at_limit_in  (carry_s[g]),
            .limit        (limit_r[g*CNT_WIDTH +: CNT_WIDTH]),
            .clr          (lvl_clr_s),
            .index        (cnt_ff[g*CNT_WIDTH +: CNT_WIDTH]),
            .at_limit_out (lvl_at_lim_s[g]),
            .wrap         (wrap_s[g])
        );
    end

    // Sweep FSM with limit latch and registered wrap/busy/done outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= IDLE;
            limit_r <= {IDX_W{1'b0}};
            wrap_r  <= {NUM_LVL{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (clr_i) begin
            state_r <= IDLE;
            wrap_r  <= {NUM_LVL{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    wrap_r <= {NUM_LVL{1'b0}};
                    done_r <= 1'b0;
                    if (start_i) begin
                        limit_r <= limit_i;
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    wrap_r <= wrap_s;
                    done_r <= complete_s;
                    if (complete_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    wrap_r  <= {NUM_LVL{1'b0}};
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign wrap_o = wrap_r;
    assign busy_o = busy_r;
    assign done_o = done_r;

endmodule

// File: doc/nested_loop_counter.md
Name: nested_loop_counter

Overview:
- Parametrised multi-level loop-index generator; successor to the single-level enable/clear counter.
- Produces NUM_LVL nested indices (level 0 innermost), each with its own runtime limit.
- Sequences fitness-evaluation sweeps (e.g. individual × gene × sample) and emits a single-cycle completion pulse.
- Sits between the evaluation controller (start/step) and the datapath address generators (indices).

Parameters:
- CNT_WIDTH, 4, width of each level's index.
- NUM_LVL, 3, number of nested levels (>=1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  latch limit_i and begin a sweep; honoured only in IDLE.
- limit_i  in  NUM_LVL*CNT_WIDTH  per-level max index (inclusive); level k at bits [k*CNT_WIDTH +: CNT_WIDTH].
- en_i  in  1  step request; advances indices one step in RUN.
- clr_i  in  1  synchronous abort/clear.
- cnt_ff  out  NUM_LVL*CNT_WIDTH  registered indices, same packing as limit_i.
- wrap_o  out  NUM_LVL  registered; bit k pulses the cycle after level k wrapped to 0.
- busy_o  out  1  high in RUN.
- done_o  out  1  registered single-cycle pulse at sweep completion.

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; cnt_ff=0, limit registers=0, wrap_o=0, busy_o=0, done_o=0.
- States: IDLE, RUN.
  - IDLE: start_i=1 -> latch limit_i, cnt_ff=0, go to RUN. en_i ignored.
  - RUN: start_i ignored; limits stay frozen.
- Step rule in RUN with en_i=1:
  - Level 0 always steps.
  - Level k>0 steps iff every level j<k equals its limit (carry chain).
  - A stepping level at its limit wraps to 0 and sets wrap_o[k]; otherwise it increments by 1.
- Completion: en_i=1 with all levels at limit.
  - All levels wrap to 0; wrap_o = all ones.
  - done_o=1 next cycle; state -> IDLE.
- en_i=0 in RUN: hold indices. wrap_o and done_o are 0 on any cycle without a step.
- Limit 0 on a level: that level is permanently at limit and always propagates carry.
- All limits 0: the first en_i completes the sweep (1 step).
- Sweep length = product of (limit_k + 1) en_i pulses.
- clr_i=1 (any state): next cycle cnt_ff=0, wrap_o=0, done_o=0, state IDLE.
  - Priority: clr_i > start_i/en_i.
- start_i and clr_i in the same cycle: clr_i wins; no sweep starts.
- Back-to-back sweeps: start_i may assert in the cycle done_o is high (state already IDLE).
- Index arithmetic is unsigned CNT_WIDTH. No overflow is possible because limit <= 2^CNT_WIDTH-1.
- Maximum index value 2^CNT_WIDTH-1 is a legal limit; wrap occurs at it.

Decomposition:
- Shared package nested_loop_pkg:
  - state enum {IDLE, RUN}.
  - localparam for the packed index width (NUM_LVL*CNT_WIDTH).
- Sub-module loop_level_cnt, instantiated NUM_LVL times via generate.
  - Inputs: step, at_limit_in, limit, clr.
  - Outputs: index, at_limit_out, wrap.
- Top holds the FSM, limit latch, carry-chain AND, and the done/wrap registers.

Test Plan (NUM_LVL=2, CNT_WIDTH=4 unless noted):
- Full sweep:
  - Stimulus: limits {L1=2, L0=3}, start, then 12 en_i pulses.
  - Response: cnt_ff sequence (0,0)(0,1)..(0,3)(1,0)..(2,3); wrap_o[0] pulses after steps 4, 8 and 12; wrap_o[1] pulses after step 12 only.
  - done_o pulses exactly once, after the 12th step; busy_o falls at the same time.
- Stall:
  - Stimulus: same limits, en_i low for 5 cycles mid-sweep at (1,2).
  - Response: indices hold at (1,2), no pulses; sweep still ends after 12 total steps.
- Clear mid-sweep:
  - Stimulus: clr_i at (2,1); then start with limits {0,0} and one en_i.
  - Response: cnt_ff=0, busy_o=0, no done_o. The new sweep completes in 1 step with done_o pulse and wrap_o=2'b11.
- Ignored inputs:
  - Stimulus: start_i during RUN with different limit_i; en_i while IDLE.
  - Response: original limits kept; IDLE indices unchanged.
- Edge widths:
  - Stimulus: NUM_LVL=3, limits all 4'hF.
  - Response: done_o after exactly 4096 steps; start_i in the done cycle begins a new sweep.
- Reset:
  - Stimulus: rst_n_i low asynchronously mid-sweep.
  - Response: all outputs 0 immediately, without waiting for a clock edge.
